fetch_unit: RTL

Instruction fetch stage of the MIPS datapath. Holds the program counter, requests instructions from instruction memory over a req/ack handshake, and presents each fetched word to decode with a valid/ready handshake. Decode splits the word and drives the 16-bit immediate into the sign extender. Taken branches and jumps redirect the PC: branch targets are built from the 32-bit sign-extended immediate returned from that extender, and jump targets from the 26-bit jump field.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_unit
// Description : MIPS instruction fetch stage. Holds the PC, fetches words
//               from instruction memory over a req/ack handshake and hands
//               them to decode over a valid/ready handshake. Taken branches
//               and jumps redirect the PC.
// Ports       : clk, reset            - clock, async active-high reset
//               imem_req/addr/ack/data - instruction memory handshake
//               instr/instr_pc4/instr_valid/instr_ready - decode handshake
//               branch_taken/branch_pc4/branch_imm/jump/jump_index - redirect
//               fetch_count            - completed decode handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc4,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc4;
    logic        r_instr_valid;
    logic [31:0] r_fetch_count;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Redirects are ignored in IDLE; jump takes precedence over a branch.
    assign w_redirect = (jump | branch_taken) & (r_state != ST_IDLE);
    assign w_target   = jump ? {branch_pc4[31:28], jump_index, 2'b00}
                             : branch_pc4 + (branch_imm << 2);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_pc4   <= 32'd0;
            r_instr_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            // A decode handshake counts even when a redirect wins the PC.
            if (r_instr_valid && instr_ready) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_redirect) begin
                        // Any word acked this cycle is dropped.
                        r_pc          <= w_target;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end else if (imem_ack) begin
                        r_instr       <= imem_data;
                        r_instr_pc4   <= w_pc_plus4;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_redirect) begin
                        r_pc          <= w_target;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end else if (instr_ready) begin
                        r_pc          <= w_pc_plus4;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc4   = r_instr_pc4;
    assign instr_valid = r_instr_valid;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
